// File: rtl/morse_keyer.sv
// Morse keyer: plays a packed dot/dash/gap bitstream as a timed on/off key signal.
// Token coding read LSB-first: 0 = dot, 10 = dash, 11 = gap token.
module morse_keyer #(
  parameter int unsigned OUT_MAX_BITS = 256,
  parameter int unsigned UNIT_CYCLES  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [OUT_MAX_BITS-1:0] bitstream,
  input  logic [8:0]              bitlen,
  output logic                    busy,
  output logic                    done,
  output logic                    key_out,
  output logic [8:0]              token_count
);

  localparam int unsigned CntW = $clog2(3 * UNIT_CYCLES);
  localparam int unsigned PtrW = ($clog2(OUT_MAX_BITS + 2) > 10) ? $clog2(OUT_MAX_BITS + 2) : 10;

  localparam logic [CntW-1:0] OneUnit   = CntW'(UNIT_CYCLES - 1);
  localparam logic [CntW-1:0] TwoUnit   = CntW'(2 * UNIT_CYCLES - 1);
  localparam logic [CntW-1:0] ThreeUnit = CntW'(3 * UNIT_CYCLES - 1);
  localparam logic [PtrW-1:0] MaxLen    = PtrW'(OUT_MAX_BITS);

  typedef enum logic [2:0] {StIdle, StParse, StOn, StOff, StDone} state_e;

  state_e                  state_q;
  logic [OUT_MAX_BITS-1:0] bits_q;
  logic [PtrW-1:0]         len_q;
  logic [PtrW-1:0]         ptr_q;
  logic [CntW-1:0]         cnt_q;

  logic [1:0]      pair;
  logic [PtrW-1:0] ptr_p1;
  logic [PtrW-1:0] bitlen_ext;
  logic            has_next;

  // The two stream bits at the read pointer; the second is only trusted when has_next.
  assign pair       = 2'(bits_q >> ptr_q);
  assign ptr_p1     = ptr_q + PtrW'(1);
  assign has_next   = ptr_p1 < len_q;
  assign bitlen_ext = PtrW'(bitlen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bits_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_out     <= 1'b0;
      token_count <= '0;
    end else if (abort && (state_q != StIdle)) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      key_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          key_out <= 1'b0;
          if (start) begin
            bits_q      <= bitstream;
            len_q       <= (bitlen_ext > MaxLen) ? MaxLen : bitlen_ext;
            ptr_q       <= '0;
            token_count <= '0;
            busy        <= 1'b1;
            state_q     <= StParse;
          end
        end
        StParse: begin
          if (ptr_q >= len_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (!pair[0]) begin
            ptr_q       <= ptr_q + PtrW'(1);
            token_count <= token_count + 9'd1;
            cnt_q       <= OneUnit;
            key_out     <= 1'b1;
            state_q     <= StOn;
          end else if (!has_next) begin
            // A lone trailing 1 is an incomplete token and is dropped.
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (!pair[1]) begin
            ptr_q       <= ptr_q + PtrW'(2);
            token_count <= token_count + 9'd1;
            cnt_q       <= ThreeUnit;
            key_out     <= 1'b1;
            state_q     <= StOn;
          end else begin
            ptr_q       <= ptr_q + PtrW'(2);
            token_count <= token_count + 9'd1;
            cnt_q       <= TwoUnit;
            state_q     <= StOff;
          end
        end
        StOn: begin
          if (cnt_q == '0) begin
            // Every keyed element is followed by exactly one silent unit.
            key_out <= 1'b0;
            cnt_q   <= OneUnit;
            state_q <= StOff;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StOff: begin
          if (cnt_q == '0) begin
            state_q <= StParse;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          key_out <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          key_out <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: a token-level model expands each stream into a per-cycle timeline
// that a monitor compares against the DUT whenever it is busy or pulsing done.
module tb_morse_keyer;

  localparam int U  = 2;
  localparam int MB = 256;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [MB-1:0] bitstream;
  logic [8:0]    bitlen;
  logic          busy;
  logic          done;
  logic          key_out;
  logic [8:0]    token_count;

  morse_keyer #(
    .OUT_MAX_BITS(MB),
    .UNIT_CYCLES (U)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .bitstream  (bitstream),
    .bitlen     (bitlen),
    .busy       (busy),
    .done       (done),
    .key_out    (key_out),
    .token_count(token_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       key;
    logic       done;
    logic [8:0] tc;
  } ent_t;

  ent_t exp_q[$];
  ent_t tr[$];
  ent_t mon_got;
  ent_t mon_exp;
  int   n_vec;
  int   n_fail;

  function automatic ent_t mk(input logic b, input logic k, input logic d, input logic [8:0] tc);
    ent_t e;
    e.busy = b;
    e.key  = k;
    e.done = d;
    e.tc   = tc;
    return e;
  endfunction

  // Walk the stream token by token and lay out the expected cycle timeline from the cycle
  // after start up to and including the done cycle.
  task automatic build(input logic [MB-1:0] bs, input int bl);
    int         len;
    int         p;
    int         n_on;
    int         n_off;
    logic [8:0] tc;
    tr.delete();
    len = (bl > MB) ? MB : bl;
    p   = 0;
    tc  = '0;
    forever begin
      tr.push_back(mk(1'b1, 1'b0, 1'b0, tc));
      if (p >= len) break;
      if (!bs[p]) begin
        n_on = 1; n_off = 1; p += 1;
      end else if (p + 1 >= len) begin
        break;
      end else if (!bs[p+1]) begin
        n_on = 3; n_off = 1; p += 2;
      end else begin
        n_on = 0; n_off = 2; p += 2;
      end
      tc = tc + 9'd1;
      repeat (n_on * U) tr.push_back(mk(1'b1, 1'b1, 1'b0, tc));
      repeat (n_off * U) tr.push_back(mk(1'b1, 1'b0, 1'b0, tc));
    end
    tr.push_back(mk(1'b0, 1'b0, 1'b1, tc));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // abort_at / restart_at / reset_at name the cycle index after start (1 = first cycle after
  // the start edge) at which that action is applied; 0 disables it.
  task automatic play(input logic [MB-1:0] bs, input int bl, input int abort_at,
                      input int restart_at, input int reset_at);
    int         k;
    int         lim;
    logic [8:0] held;
    build(bs, bl);
    lim = tr.size() + 20;
    for (int i = 0; i < tr.size(); i++) begin
      if (abort_at == 0 || i < abort_at) exp_q.push_back(tr[i]);
    end
    bitstream = bs;
    bitlen    = 9'(bl);
    start     = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (k < lim) begin
      if (abort_at > 0 && k == abort_at) begin
        held  = tr[k-1].tc;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_key", int'(key_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_token_count", int'(token_count), int'(held));
        break;
      end
      if (reset_at > 0 && k == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("areset_key", int'(key_out), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_token_count", int'(token_count), 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        break;
      end
      if (abort_at == 0 && reset_at == 0 && exp_q.size() == 0) break;
      if (k == restart_at) begin
        start     = 1'b1;
        bitstream = {8{$urandom()}};
        bitlen    = 9'($urandom_range(0, 511));
      end
      step();
      start = 1'b0;
      k++;
    end
    if (k >= lim) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: %0d expected cycles never presented", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  logic [MB-1:0] rbs;
  int            rbl;
  int            mode;
  int            ab;
  int            rs;

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    bitstream = '0;
    bitlen    = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && (busy || done)) begin
          mon_got = mk(busy, key_out, done, token_count);
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output t=%0t: busy=%0b key=%0b done=%0b tc=%0d, none expected",
                     $time, mon_got.busy, mon_got.key, mon_got.done, mon_got.tc);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
              n_fail++;
              $display("FAIL waveform t=%0t: got busy=%0b key=%0b done=%0b tc=%0d, required busy=%0b key=%0b done=%0b tc=%0d",
                       $time, mon_got.busy, mon_got.key, mon_got.done, mon_got.tc,
                       mon_exp.busy, mon_exp.key, mon_exp.done, mon_exp.tc);
            end
          end
        end
      end
    join_none

    repeat (3) step();
    chk("reset_key", int'(key_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_token_count", int'(token_count), 0);
    rst_n = 1'b1;
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_key", int'(key_out), 0);

    play(256'h6, 3, 0, 0, 0);                 // "E" then letter gap
    play(256'hFD, 8, 0, 0, 0);                // "T" then space
    play(256'h2, 2, 0, 0, 0);                 // dot then truncated 1
    play(256'h155, 10, 12, 0, 0);             // "0", aborted in the 2nd dash
    play(256'h155, 10, 0, 0, 0);              // full replay from bit 0
    rbs = {8{$urandom()}};
    play(rbs, 300, 0, 7, 0);                  // clamp to 256, restart ignored
    play(256'h155, 10, 0, 0, 4);              // async reset inside the first dash
    play('0, 0, 0, 0, 0);                     // empty stream after reset

    for (int it = 0; it < 20; it++) begin
      rbs  = {8{$urandom()}};
      rbl  = $urandom_range(0, 48);
      mode = $urandom_range(0, 3);
      build(rbs, rbl);
      ab = 0;
      rs = 0;
      if (mode == 1) ab = $urandom_range(1, tr.size() - 1);
      if (mode == 2) rs = $urandom_range(1, tr.size() - 1);
      play(rbs, rbl, ab, rs, 0);
    end

    repeat (4) step();
    chk("leftover_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
